exec_unit: RTL

Parametrised execution unit for the multicycle core. It wraps operand capture, the ALU, a result register and a full NZCV flag register behind a start/busy/done handshake, so the controller no longer sequences these registers itself. Compared with the current fixed 32-bit datapath ALU, it adds width parametrisation, a 16-code condition evaluator, carry-in ops, shifts and an iterative multiplier. It sits between the register-file A/B latches and the ALUOut/writeback path, and is driven by the main control FSM.

---
 rtl/exec_unit.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/exec_unit.sv
// Execution unit: latches operands on start, runs single-cycle ALU/shift ops or an
// iterative shift-add multiply, and keeps a registered result and NZCV flag register.
module exec_unit #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_flags,
    input  logic [3:0]       cond,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done,
    output logic             cond_pass
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_RSB = 4'd2,  OP_AND = 4'd3;
    localparam logic [3:0] OP_ORR = 4'd4,  OP_EOR = 4'd5,  OP_MOV = 4'd6,  OP_MVN = 4'd7;
    localparam logic [3:0] OP_CMP = 4'd8,  OP_TST = 4'd9,  OP_ADC = 4'd10, OP_SBC = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12, OP_LSL = 4'd13, OP_LSR = 4'd14, OP_ASR = 4'd15;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [3:0]       flags_reg, flags_next;
    logic             done_reg, done_next;
    logic [WIDTH-1:0] mcand_reg, mcand_next;
    logic [WIDTH-1:0] mplier_reg, mplier_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [SW-1:0]    count_reg, count_next;
    logic             mul_sf_reg, mul_sf_next;

    logic             c_flag;
    logic [WIDTH-1:0] add_x, add_y;
    logic             add_cin;
    logic [WIDTH:0]   sum;
    logic             add_v;
    logic [SW-1:0]    amt;
    logic [WIDTH:0]   shl, shr;
    logic signed [WIDTH:0] sar;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, wr_res, wr_flags;
    logic [WIDTH-1:0] acc_sum;

    assign c_flag = flags_reg[1];

    // Subtracts are a + ~b + 1; carry-in variants substitute the held C for the +1.
    always_comb begin
        add_x   = a;
        add_y   = b;
        add_cin = 1'b0;
        case (op)
            OP_SUB, OP_CMP: begin add_y = ~b; add_cin = 1'b1; end
            OP_RSB:         begin add_x = b; add_y = ~a; add_cin = 1'b1; end
            OP_ADC:         add_cin = c_flag;
            OP_SBC:         begin add_y = ~b; add_cin = c_flag; end
            default:        ;
        endcase
    end

    assign sum   = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    assign add_v = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);

    // One spare bit on each shifter catches the last bit shifted out.
    assign amt = b[SW-1:0];
    assign shl = {1'b0, a} << amt;
    assign shr = {a, 1'b0} >> amt;
    assign sar = $signed({a, 1'b0}) >>> amt;

    always_comb begin
        alu_res  = '0;
        alu_c    = flags_reg[1];
        alu_v    = flags_reg[0];
        wr_res   = 1'b1;
        wr_flags = set_flags;
        case (op)
            OP_ADD, OP_SUB, OP_RSB, OP_ADC, OP_SBC: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = add_v;
            end
            OP_CMP: begin
                alu_res  = sum[WIDTH-1:0];
                alu_c    = sum[WIDTH];
                alu_v    = add_v;
                wr_res   = 1'b0;
                wr_flags = 1'b1;
            end
            OP_AND: alu_res = a & b;
            OP_ORR: alu_res = a | b;
            OP_EOR: alu_res = a ^ b;
            OP_MOV: alu_res = b;
            OP_MVN: alu_res = ~b;
            OP_TST: begin
                alu_res  = a & b;
                wr_res   = 1'b0;
                wr_flags = 1'b1;
            end
            OP_LSL: begin
                alu_res = shl[WIDTH-1:0];
                if (amt != '0) alu_c = shl[WIDTH];
            end
            OP_LSR: begin
                alu_res = shr[WIDTH:1];
                if (amt != '0) alu_c = shr[0];
            end
            OP_ASR: begin
                alu_res = sar[WIDTH:1];
                if (amt != '0) alu_c = sar[0];
            end
            default: wr_flags = 1'b0;  // MUL without a multiplier: result 0, flags kept
        endcase
    end

    assign acc_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        flags_next  = flags_reg;
        done_next   = 1'b0;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        acc_next    = acc_reg;
        count_next  = count_reg;
        mul_sf_next = mul_sf_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (op == OP_MUL && MUL_EN) begin
                        state_next  = MUL;
                        mcand_next  = a;
                        mplier_next = b;
                        acc_next    = '0;
                        count_next  = SW'(WIDTH - 1);
                        mul_sf_next = set_flags;
                    end else begin
                        done_next = 1'b1;
                        if (wr_res)   result_next = alu_res;
                        if (wr_flags) flags_next  = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
                    end
                end
            end
            MUL: begin
                acc_next    = acc_sum;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                count_next  = count_reg - 1'b1;
                if (count_reg == '0) begin
                    state_next  = IDLE;
                    result_next = acc_sum;
                    done_next   = 1'b1;
                    if (mul_sf_reg) flags_next = {acc_sum[WIDTH-1], acc_sum == '0, flags_reg[1:0]};
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            result_reg <= '0;
            flags_reg  <= '0;
            done_reg   <= 1'b0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            count_reg  <= '0;
            mul_sf_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            flags_reg  <= flags_next;
            done_reg   <= done_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            acc_reg    <= acc_next;
            count_reg  <= count_next;
            mul_sf_reg <= mul_sf_next;
        end
    end

    // ARM condition codes evaluated against the committed flag register.
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags_reg;
        cond_pass = 1'b0;
        case (cond)
            4'd0:  cond_pass = z;
            4'd1:  cond_pass = !z;
            4'd2:  cond_pass = c;
            4'd3:  cond_pass = !c;
            4'd4:  cond_pass = n;
            4'd5:  cond_pass = !n;
            4'd6:  cond_pass = v;
            4'd7:  cond_pass = !v;
            4'd8:  cond_pass = c && !z;
            4'd9:  cond_pass = !c || z;
            4'd10: cond_pass = (n == v);
            4'd11: cond_pass = (n != v);
            4'd12: cond_pass = !z && (n == v);
            4'd13: cond_pass = z || (n != v);
            4'd14: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign result = result_reg;
    assign flags  = flags_reg;
    assign done   = done_reg;
    assign busy   = (state_reg == MUL);
endmodule
